rf_write_demux_bypass: RTL and testbench

//  Register file whose write side is a 1:N decoded demux steering one write port into N registers.
//  Two read ports select via N:1 muxes; a same-cycle write is bypassed to the readers.

---
 rtl/rf_write_demux_bypass_pkg.sv | 22 ++
 rtl/rf_write_demux_bypass_if.sv | 23 ++
 rtl/rf_write_demux_bypass_reg_en.sv | 21 ++
 rtl/rf_write_demux_bypass.sv | 64 ++++++
 tb/tb_rf_write_demux_bypass.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/rf_write_demux_bypass_pkg.sv
// rtl/rf_write_demux_bypass_pkg.sv - shared widths, types and write-decode helper for the register file
package rf_write_demux_bypass_pkg;

    localparam int WIDTH = 16;
    localparam int SELW  = 3;
    localparam int NREGS = 2 ** SELW;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SELW-1:0]  sel_t;
    typedef logic [NREGS-1:0] onehot_t;

    // One-hot write enables; all zero when the strobe is low
    function automatic onehot_t write_decode(input logic en, input sel_t sel);
        onehot_t dec;
        dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            dec[i] = en & (sel == sel_t'(i));
        end
        return dec;
    endfunction

endpackage

// File: rtl/rf_write_demux_bypass_if.sv
// rtl/rf_write_demux_bypass_if.sv - write port, two read ports and error flag of the register file
interface rf_write_demux_bypass_if;
    import rf_write_demux_bypass_pkg::*;

    logic  writeEn;
    sel_t  writeRegSel;
    word_t writeData;
    sel_t  read1RegSel;
    sel_t  read2RegSel;
    word_t read1Data;
    word_t read2Data;
    logic  err;

    modport master (
        output writeEn, writeRegSel, writeData, read1RegSel, read2RegSel,
        input  read1Data, read2Data, err
    );

    modport slave (
        input  writeEn, writeRegSel, writeData, read1RegSel, read2RegSel,
        output read1Data, read2Data, err
    );
endinterface

// File: rtl/rf_write_demux_bypass_reg_en.sv
// rtl/rf_write_demux_bypass_reg_en.sv - WIDTH-bit register with async clear and write enable
module reg_en #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over any write on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rf_write_demux_bypass.sv
// rtl/rf_write_demux_bypass.sv - register file with decoded write demux, two read muxes and write bypass
module rf_write_demux_bypass
    import rf_write_demux_bypass_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    rf_write_demux_bypass_if.slave  bus
);

    onehot_t en;
    word_t   regs [NREGS];
    logic    bypass1;
    logic    bypass2;
    logic    bad_write;
    logic    err_q;

    // Steer the single write port into exactly one register
    always_comb begin
        en = write_decode(bus.writeEn, bus.writeRegSel);
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs
        reg_en #(.WIDTH(WIDTH)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (en[g]),
            .d   (bus.writeData),
            .q   (regs[g])
        );
    end

    // Forward a same-cycle write to each reader; suppressed during reset
    always_comb begin
        bypass1 = !rst && bus.writeEn && (bus.read1RegSel == bus.writeRegSel);
        bypass2 = !rst && bus.writeEn && (bus.read2RegSel == bus.writeRegSel);
    end

    // Read muxes; outputs forced to zero while reset is held
    always_comb begin
        bus.read1Data = '0;
        bus.read2Data = '0;
        if (!rst) begin
            bus.read1Data = bypass1 ? bus.writeData : regs[bus.read1RegSel];
            bus.read2Data = bypass2 ? bus.writeData : regs[bus.read2RegSel];
        end
    end

    // Unknown bits on an enabled write; constant 0 once synthesised
    always_comb begin
        bad_write = bus.writeEn && ((^{bus.writeRegSel, bus.writeData}) === 1'bx);
    end

    // Sticky error flag, only cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad_write) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;

endmodule

// File: tb/tb_rf_write_demux_bypass.sv
// tb/tb_rf_write_demux_bypass.sv - directed scoreboard bench for the bypassed register file
module tb_rf_write_demux_bypass;
    import rf_write_demux_bypass_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_write_demux_bypass_if bus ();

    rf_write_demux_bypass dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string tag;
        word_t e1;
        word_t e2;
    } exp_t;

    exp_t  sb[$];
    word_t model [NREGS];
    logic  exp_err;
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_err(input string tag);
        checks++;
        assert (bus.err === exp_err) else begin
            errors++;
            $error("FAIL %s: observed err=%b expected err=%b", tag, bus.err, exp_err);
        end
    endtask

    task automatic pop_and_compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, "/rd1"}, bus.read1Data, e.e1);
            check({e.tag, "/rd2"}, bus.read2Data, e.e2);
        end
    endtask

    function automatic word_t expect_read(input logic we, input sel_t wsel, input word_t wdata, input sel_t rsel);
        if (rst) return '0;
        if (we && rsel == wsel) return wdata;
        return model[rsel];
    endfunction

    // One cycle starting just after a rising edge: drive, check reads at the falling edge, clock it in
    task automatic cycle_op(input string tag, input logic we, input sel_t wsel, input word_t wdata,
                            input sel_t r1, input sel_t r2);
        exp_t e;
        bus.writeEn     = we;
        bus.writeRegSel = wsel;
        bus.writeData   = wdata;
        bus.read1RegSel = r1;
        bus.read2RegSel = r2;
        e.tag = tag;
        e.e1  = expect_read(we, wsel, wdata, r1);
        e.e2  = expect_read(we, wsel, wdata, r2);
        sb.push_back(e);
        @(negedge clk);
        pop_and_compare();
        @(posedge clk);
        if (!rst && we) model[wsel] = wdata;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        exp_err = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.writeEn     = 1'b0;
        bus.writeRegSel = '0;
        bus.writeData   = '0;
        bus.read1RegSel = '0;
        bus.read2RegSel = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_err("reset_err");
        cycle_op("reset_read_r0", 1'b0, 3'd0, 16'h0, 3'd0, 3'd7);
        rst = 1'b0;

        // Basic write then read
        cycle_op("write_r3", 1'b1, 3'd3, 16'hBEEF, 3'd1, 3'd2);
        cycle_op("read_r3_r0", 1'b0, 3'd0, 16'h0, 3'd3, 3'd0);

        // Bypass on both ports at once
        cycle_op("bypass_both_r5", 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5);
        cycle_op("read_r5_r3", 1'b0, 3'd0, 16'h0, 3'd5, 3'd3);

        // Bypass on one port only; the other sees stale value of a different register
        cycle_op("bypass_rd2_only", 1'b1, 3'd3, 16'hCAFE, 3'd5, 3'd3);

        // Same register on consecutive cycles: last write wins, each cycle bypasses
        cycle_op("consec_w1", 1'b1, 3'd6, 16'hAAAA, 3'd6, 3'd6);
        cycle_op("consec_w2", 1'b1, 3'd6, 16'h5555, 3'd6, 3'd0);
        cycle_op("consec_w3", 1'b1, 3'd6, 16'h0F0F, 3'd1, 3'd6);
        cycle_op("consec_final", 1'b0, 3'd6, 16'hFFFF, 3'd6, 3'd6);

        // Walk every register, reading the just-written one by bypass and its neighbour stale
        for (int k = 0; k < NREGS; k++) begin
            cycle_op($sformatf("walk_w%0d", k), 1'b1, sel_t'(k), word_t'(16'h1111 * k),
                     sel_t'(k), sel_t'((k + 1) % NREGS));
        end
        for (int k = 0; k < NREGS; k++) begin
            cycle_op($sformatf("walk_rd%0d", k), 1'b0, 3'd0, 16'h0, sel_t'(k), sel_t'(NREGS - 1 - k));
        end
        check_err("err_clean_run");

        // Asynchronous reset mid-cycle: reads drop before any edge
        bus.writeEn     = 1'b0;
        bus.read1RegSel = 3'd7;
        bus.read2RegSel = 3'd4;
        #1;
        rst = 1'b1;
        #1;
        clear_model();
        check("async_reset_rd1", bus.read1Data, 16'h0);
        check("async_reset_rd2", bus.read2Data, 16'h0);
        @(posedge clk);
        #1;
        for (int k = 0; k < NREGS; k += 2) begin
            cycle_op($sformatf("reset_hold_rd%0d", k), 1'b0, 3'd0, 16'h0, sel_t'(k), sel_t'(k + 1));
        end

        // Write under reset is discarded and not bypassed
        cycle_op("write_in_reset", 1'b1, 3'd2, 16'hFFFF, 3'd2, 3'd2);
        rst = 1'b0;
        cycle_op("after_reset_r2", 1'b0, 3'd0, 16'h0, 3'd2, 3'd3);
        check_err("err_after_reset");

        // Unknown select on an enabled write raises the sticky flag
        bus.writeEn     = 1'b1;
        bus.writeRegSel = 3'bx1x;
        bus.writeData   = 16'h7777;
        #1;
        if ((^bus.writeRegSel) === 1'bx) exp_err = 1'b1;
        @(posedge clk);
        #1;
        bus.writeEn     = 1'b0;
        bus.writeRegSel = 3'd0;
        check_err("err_set");
        repeat (2) @(posedge clk);
        #1;
        check_err("err_sticky");
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
        check_err("err_cleared_in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_err("err_cleared_after");
        cycle_op("post_err_read", 1'b1, 3'd1, 16'h2468, 3'd1, 3'd2);
        cycle_op("post_err_readback", 1'b0, 3'd0, 16'h0, 3'd1, 3'd2);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
